// File: rtl/uart_tx_cfg_if.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg_if -- frame request / status bundle for the configurable UART
// transmitter (uart_tx_cfg).
//
// Parameter:
//   DBIT         data bits per frame (5..9); must match the transmitter's DBIT
//
// Signals:
//   tx_valid     frame request from the producer
//   din          frame data, LSB transmitted first
//   parity_mode  00 none, 01 even, 10 odd, 11 none
//   stop_mode    00 one, 01 one-and-a-half, 10 two, 11 one stop bit
//   tx_ready     transmitter idle and able to accept a frame
//   tx_done_tick one-clk pulse in the cycle the final stop tick is counted
//   busy         frame in progress (inverse of tx_ready)
//   tx           registered serial line, idle high
//
// Modports:
//   master       producer side (drives the request and frame settings)
//   slave        transmitter side (drives status and the serial line)
// ---------------------------------------------------------------------------
interface uart_tx_cfg_if #(
  parameter int DBIT = 8
);
  logic            tx_valid;
  logic [DBIT-1:0] din;
  logic [1:0]      parity_mode;
  logic [1:0]      stop_mode;
  logic            tx_ready;
  logic            tx_done_tick;
  logic            busy;
  logic            tx;

  modport master (
    output tx_valid, din, parity_mode, stop_mode,
    input  tx_ready, tx_done_tick, busy, tx
  );

  modport slave (
    input  tx_valid, din, parity_mode, stop_mode,
    output tx_ready, tx_done_tick, busy, tx
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg -- UART transmitter with per-frame parity and stop-bit settings.
//
// A frame is accepted when tx_valid is high while the block is idle; din and
// both mode fields are captured at that edge, so later changes on the bus
// have no effect on the frame in flight. Bit timing is counted in s_tick
// pulses (OVERSAMPLE per bit); clk cycles without s_tick do not advance.
//
// Parameters:
//   DBIT         data bits per frame, 5..9
//   OVERSAMPLE   s_tick pulses per bit, even, 8..32
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   s_tick       baud-rate enable, one clk wide
//   bus          uart_tx_cfg_if.slave: tx_valid, din, parity_mode, stop_mode
//                in; tx_ready, tx_done_tick, busy, tx out
//
// Build option:
//   UART_TX_PARITY_EN  when defined, even/odd parity is generated from the
//                      latched parity_mode. When undefined the PARITY state
//                      and parity logic are absent, parity_mode is ignored
//                      and every frame is sent without a parity bit.
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_tick,
  uart_tx_cfg_if.slave  bus
);

  // Tick counter must hold up to 2*OVERSAMPLE-1 (two stop bits) without wrap.
  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] BIT_LAST    = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP1_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'((3 * OVERSAMPLE) / 2 - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST   = BW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q,  tick_d;
  logic [BW-1:0]   bit_q,   bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [1:0]      stop_q,  stop_d;
  logic            tx_q;

`ifdef UART_TX_PARITY_EN
  logic            par_en_q,  par_en_d;
  logic            par_bit_q, par_bit_d;
`endif

  logic [TW-1:0]   stop_last;
  logic [TW-1:0]   tick_last;
  logic            bit_end;
  logic            line;
  logic            done;

  // Stop length comes from the latched mode; reserved 11 falls back to one bit.
  always_comb begin
    stop_last = STOP1_LAST;
    case (stop_q)
      2'b01:   stop_last = STOP15_LAST;
      2'b10:   stop_last = STOP2_LAST;
      default: stop_last = STOP1_LAST;
    endcase
  end

  assign tick_last = (state_q == STOP) ? stop_last : BIT_LAST;

  // True in the cycle that counts the last tick of the current bit period.
  assign bit_end = s_tick && (tick_q == tick_last);

  // Next-state, datapath updates and line value
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    stop_d  = stop_q;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    line    = 1'b1;
    done    = 1'b0;

    // The counter restarts at every bit boundary, so it never wraps mid-bit.
    if (state_q != IDLE && s_tick) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        line = 1'b1;
        if (bus.tx_valid) begin
          state_d = START;
          tick_d  = '0;
          bit_d   = '0;
          shreg_d = bus.din;
          stop_d  = bus.stop_mode;
`ifdef UART_TX_PARITY_EN
          // Parity is fixed at acceptance because the shift register is
          // consumed as the data goes out.
          par_en_d  = (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
          par_bit_d = (^bus.din) ^ (bus.parity_mode == 2'b10);
`endif
        end
      end

      START: begin
        line = 1'b0;
        if (bit_end) begin
          state_d = DATA;
        end
      end

      DATA: begin
        line = shreg_q[0];
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line = par_bit_q;
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        line = 1'b1;
        if (bit_end) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      stop_q  <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      stop_q  <= stop_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  // Serial line register: one clk behind the state it represents
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_q <= 1'b1;
    end else begin
      tx_q <= line;
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_ready     = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  // A reset arriving in the final stop cycle abandons the frame silently.
  assign bus.tx_done_tick = done & reset_n;

endmodule
